// File: rtl/add_pkg.sv
// Shared constants for the segmented pipelined adder.
package add_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int ADD_SEG    = 8;
    localparam int ADD_STAGES = ADD_WIDTH / ADD_SEG;

    // Number of pipeline stages needed to resolve a width-bit sum seg bits at a time.
    function automatic int calc_stages(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/add_pipe_n_if.sv
// Operand/result handshake bundle for add_pipe_n.
interface add_pipe_n_if
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/add_seg.sv
// Combinational SEG-bit ripple-carry adder segment.
module add_seg
    import add_pkg::*;
#(
    parameter int SEG = ADD_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out
);

    logic [SEG:0] cy_s;

    // Ripple the carry bit by bit through the segment.
    always_comb begin
        cy_s    = '0;
        sum     = '0;
        cy_s[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            sum[i]    = a[i] ^ b[i] ^ cy_s[i];
            cy_s[i+1] = (a[i] & b[i]) | (cy_s[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out = cy_s[SEG];

endmodule

// File: rtl/add_pipe_n.sv
// Pipelined adder/subtractor: one SEG-bit slice of the sum resolved per stage,
// valid/ready handshake on both sides with per-stage back-pressure.
module add_pipe_n
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SEG   = ADD_SEG
) (
    input  logic         clock,
    input  logic         clear_n,
    add_pipe_n_if.slave  bus
);

    localparam int STAGES = calc_stages(WIDTH, SEG);
    localparam int LAST   = STAGES - 1;

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] adv_s;

    // A stage may load when it is empty or its successor is moving on.
    always_comb begin
        adv_s       = '0;
        adv_s[LAST] = !vld_s[LAST] || bus.out_ready;
        for (int i = LAST - 1; i >= 0; i--) begin
            adv_s[i] = !vld_s[i] || adv_s[i+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be resolved entering this stage, and sum bits known after it.
        localparam int SRC_W = WIDTH - k * SEG;
        localparam int LO_W  = (k + 1) * SEG;

        logic [SRC_W-1:0] src_a_s;
        logic [SRC_W-1:0] src_b_s;
        logic             src_cy_s;
        logic             src_vld_s;
        logic [SEG-1:0]   seg_sum_s;
        logic             seg_cy_s;
        logic [LO_W-1:0]  nxt_sum_s;

        logic             vld_r;
        logic             cy_r;
        logic [LO_W-1:0]  sum_r;

        if (k == 0) begin : g_src
            // Subtraction folds into addition of ~b with a forced carry-in.
            assign src_a_s   = bus.a;
            assign src_b_s   = bus.sub ? ~bus.b : bus.b;
            assign src_cy_s  = bus.sub ? 1'b1 : bus.c_in;
            assign src_vld_s = bus.in_valid;
            assign nxt_sum_s = seg_sum_s;
        end else begin : g_src
            assign src_a_s   = g_stage[k-1].g_fwd.a_hi_r;
            assign src_b_s   = g_stage[k-1].g_fwd.b_hi_r;
            assign src_cy_s  = g_stage[k-1].cy_r;
            assign src_vld_s = g_stage[k-1].vld_r;
            assign nxt_sum_s = {seg_sum_s, g_stage[k-1].sum_r};
        end

        add_seg #(.SEG(SEG)) u_seg (
            .a     (src_a_s[SEG-1:0]),
            .b     (src_b_s[SEG-1:0]),
            .c_in  (src_cy_s),
            .sum   (seg_sum_s),
            .c_out (seg_cy_s)
        );

        assign vld_s[k] = vld_r;

        // Stage valid, carry and resolved low sum bits; held while stalled.
        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                vld_r <= 1'b0;
                cy_r  <= 1'b0;
                sum_r <= '0;
            end else if (adv_s[k]) begin
                vld_r <= src_vld_s;
                if (src_vld_s) begin
                    cy_r  <= seg_cy_s;
                    sum_r <= nxt_sum_s;
                end
            end
        end

        if (k < LAST) begin : g_fwd
            localparam int HI_W = SRC_W - SEG;

            logic [HI_W-1:0] a_hi_r;
            logic [HI_W-1:0] b_hi_r;

            // Carry the unresolved upper operand bits to the next stage.
            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    a_hi_r <= '0;
                    b_hi_r <= '0;
                end else if (adv_s[k] && src_vld_s) begin
                    a_hi_r <= src_a_s[SRC_W-1:SEG];
                    b_hi_r <= src_b_s[SRC_W-1:SEG];
                end
            end
        end

        if (k == LAST) begin : g_ovf
            logic ovf_r;

            // Signed overflow: operands agree in sign but the sum does not.
            always_ff @(posedge clock or negedge clear_n) begin
                if (!clear_n) begin
                    ovf_r <= 1'b0;
                end else if (adv_s[k] && src_vld_s) begin
                    ovf_r <= (src_a_s[SRC_W-1] == src_b_s[SRC_W-1]) &&
                             (nxt_sum_s[WIDTH-1] != src_a_s[SRC_W-1]);
                end
            end
        end
    end

    assign bus.in_ready  = adv_s[0];
    assign bus.out_valid = g_stage[LAST].vld_r;
    assign bus.sum       = g_stage[LAST].sum_r;
    assign bus.c_out     = g_stage[LAST].cy_r;
    assign bus.ovf       = g_stage[LAST].g_ovf.ovf_r;

endmodule

// File: tb/tb_add_pipe_n.sv
// Self-checking bench for add_pipe_n: directed corner cases, a randomized
// back-pressured stream against a scoreboard, mid-flight reset, 16/4 instance.
module tb_add_pipe_n;

    localparam int STG = 4;

    typedef struct packed {
        logic        ovf;
        logic        c_out;
        logic [31:0] sum;
    } res_t;

    logic clk     = 1'b0;
    logic clear_n = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_emit   = 0;
    res_t sb_q[$];

    add_pipe_n_if #(.WIDTH(32)) bus ();
    add_pipe_n_if #(.WIDTH(16)) bus16 ();

    add_pipe_n #(.WIDTH(32), .SEG(8)) u_dut (
        .clock   (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    add_pipe_n #(.WIDTH(16), .SEG(4)) u_dut16 (
        .clock   (clk),
        .clear_n (clear_n),
        .bus     (bus16)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operands.
    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic cin, input logic sub);
        longint     sa, sb, sr;
        logic [32:0] u;
        res_t       r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            sr      = sa - sb;
            r.c_out = (a >= b);
        end else begin
            sr      = sa + sb + longint'(cin);
            u       = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            r.c_out = u[32];
        end
        r.sum = sr[31:0];
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return r;
    endfunction

    // Scoreboard monitor, sampled mid-cycle: transfers happen at the next rising edge.
    always @(negedge clk) begin
        if (clear_n) begin
            check_val("in_ready_rule", bus.in_ready, (sb_q.size() < STG) || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("out_unexpected", bus.out_valid, 1'b0);
                end else begin
                    res_t e;
                    e = sb_q.pop_front();
                    n_emit++;
                    check_val("out_sum",   bus.sum,   e.sum);
                    check_val("out_c_out", bus.c_out, e.c_out);
                    check_val("out_ovf",   bus.ovf,   e.ovf);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(ref_model(bus.a, bus.b, bus.c_in, bus.sub));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int cyc;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!bus.in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_val("send_timeout", (cyc < 200), 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                           input logic [31:0] es, input logic ec, input logic eo, input string tag);
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) begin
                @(posedge clk);
                #1;
            end
            check_val({tag, "_lat"}, bus.out_valid, (e == 4));
        end
        check_val({tag, "_sum"},   bus.sum,   es);
        check_val({tag, "_c_out"}, bus.c_out, ec);
        check_val({tag, "_ovf"},   bus.ovf,   eo);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bus.in_valid    = 1'b1;
        bus.a           = 32'h0000_0003;
        bus.b           = 32'h0000_0004;
        bus.c_in        = 1'b0;
        bus.sub         = 1'b0;
        bus.out_ready   = 1'b1;
        bus16.in_valid  = 1'b1;
        bus16.a         = 16'h0001;
        bus16.b         = 16'h0001;
        bus16.c_in      = 1'b0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset held across several edges with input offered.
        repeat (5) @(posedge clk);
        #1;
        check_val("rst_out_valid", bus.out_valid, 1'b0);
        check_val("rst_sum",       bus.sum,       32'h0);
        check_val("rst_c_out",     bus.c_out,     1'b0);
        check_val("rst_ovf",       bus.ovf,       1'b0);
        check_val("rst_in_ready",  bus.in_ready,  1'b1);
        check_val("rst16_out_valid", bus16.out_valid, 1'b0);
        bus.in_valid   = 1'b0;
        bus16.in_valid = 1'b0;
        clear_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_rst_in_ready", bus.in_ready, 1'b1);

        // Directed corner cases.
        run_one(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, "add_basic");
        run_one(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
        run_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_cin_ign");
        run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
        run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry_wrap");
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");

        // Back-to-back random stream with a 6-cycle downstream stall.
        n_emit = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1;
                check_val("stall_in_ready",  bus.in_ready,  1'b0);
                check_val("stall_out_valid", bus.out_valid, 1'b1);
                bus.out_ready = 1'b1;
            end
        join
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_val("stream_drain", sb_q.size(), 0);
        check_val("stream_count", n_emit, 16);

        // Reset with three results in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send($urandom(), $urandom(), 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("pre_rst_valid", bus.out_valid, 1'b1);
        #2;
        clear_n = 1'b0;
        sb_q.delete();
        #1;
        check_val("mid_rst_out_valid", bus.out_valid, 1'b0);
        check_val("mid_rst_sum",       bus.sum,       32'h0);
        check_val("mid_rst_c_out",     bus.c_out,     1'b0);
        check_val("mid_rst_ovf",       bus.ovf,       1'b0);
        check_val("mid_rst_in_ready",  bus.in_ready,  1'b1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("no_stale", bus.out_valid, 1'b0);
        end
        run_one(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 32'hEFBE_D000, 1'b0, 1'b0, "after_rst");

        // 16-bit, 4-bit-segment instance carry wrap.
        bus16.a        = 16'hFFFF;
        bus16.b        = 16'h0001;
        bus16.c_in     = 1'b0;
        bus16.sub      = 1'b0;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            if (e > 1) begin
                @(posedge clk);
                #1;
            end
            check_val("w16_lat", bus16.out_valid, (e == 4));
        end
        check_val("w16_sum",   bus16.sum,   16'h0000);
        check_val("w16_c_out", bus16.c_out, 1'b1);
        check_val("w16_ovf",   bus16.ovf,   1'b0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
